jtcop_bac06_romarb: RTL



---
 rtl/jtcop_bac06_romarb.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/jtcop_bac06_romarb.sv
// Round-robin arbiter sharing one 32-bit graphics ROM port among the three
// BAC06 tilemap layers, with a per-layer result latch so hits need no ROM access.
module jtcop_bac06_romarb #(
    parameter int AW   = 19,
    parameter int TOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      l_cs,
    input  logic [3*AW-1:0] l_addr,
    output logic [3*32-1:0] l_data,
    output logic [2:0]      l_ok,
    output logic            rom_cs,
    output logic [AW-1:0]   rom_addr,
    input  logic [31:0]     rom_data,
    input  logic            rom_ok,
    output logic            tout_err
);

    localparam int WW = $clog2(TOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_gnt;
    logic [1:0]      r_rr;
    logic [AW-1:0]   r_tag [3];
    logic [31:0]     r_data [3];
    logic [2:0]      r_valid;
    logic [WW-1:0]   r_wdog;

    logic [AW-1:0]   w_addr [3];
    logic [2:0]      w_hit;
    logic [2:0]      w_need;
    logic [1:0]      w_sel;
    logic            w_any;
    logic            w_grant;
    logic            w_done;
    logic            w_tout;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // The hit compare uses only registered tag/valid, so l_ok follows l_addr
    // within the same cycle and drops as soon as the layer moves on.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_addr[i] = l_addr[i*AW +: AW];
            w_hit[i]  = l_cs[i] & r_valid[i] & (w_addr[i] == r_tag[i]);
            w_need[i] = l_cs[i] & ~w_hit[i];
        end
    end

    assign l_ok = w_hit;

    for (genvar g = 0; g < 3; g++) begin : g_out
        assign l_data[g*32 +: 32] = r_data[g];
    end

    always_comb begin
        logic [1:0] idx;
        idx   = r_rr;
        w_sel = r_rr;
        w_any = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!w_any && w_need[idx]) begin
                w_sel = idx;
                w_any = 1'b1;
            end
            idx = inc3(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ISSUE deliberately ignores rom_ok: it may still be high from the
    // previous address while the controller has not yet seen the new one.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rom_ok) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wdog == WW'(TOUT - 1)) begin
                    w_tout      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            r_gnt    <= 2'd0;
            r_rr     <= 2'd0;
            tout_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt    <= w_sel;
                rom_addr <= w_addr[w_sel];
                rom_cs   <= 1'b1;
            end
            if (w_done || w_tout) begin
                rom_cs <= 1'b0;
                r_rr   <= inc3(r_gnt);
            end
            if (w_tout) begin
                tout_err <= 1'b1;
            end
        end
    end

    // The tag stored is the address actually fetched, so a layer that moved
    // during the fetch misses and simply requests again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_valid[w_sel] <= 1'b0;
            end
            if (w_done) begin
                r_data[r_gnt]  <= rom_data;
                r_tag[r_gnt]   <= rom_addr;
                r_valid[r_gnt] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT && !w_done && !w_tout) begin
            r_wdog <= r_wdog + WW'(1);
        end else begin
            r_wdog <= '0;
        end
    end

endmodule
